// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the multicycle ARM control unit:
//   - FSM state encoding
//   - ALUControl encodings
//   - instruction op / cmd / cond field constants
//   - ImmSrc / ResultSrc / ALUSrcB select constants
//   - decode_cmd(): maps a data-processing cmd to ALU operation and write enables
// -----------------------------------------------------------------------------
package arm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // op field (Instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // cmd field (Instr[24:21])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // cond field (Instr[31:28])
  localparam logic [3:0] COND_AL = 4'b1110;

  // ImmSrc selects
  localparam logic [1:0] IMM_ROT8 = 2'b00;
  localparam logic [1:0] IMM_12   = 2'b01;
  localparam logic [1:0] IMM_24   = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       reg_wr;
    logic       flag_wr;
  } cmd_dec_t;

  // Unsupported commands fall back to ADD and suppress every architectural
  // side effect, so they behave as a harmless NOP through ALUWB.
  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d.alu_ctrl = ALU_ADD;
    d.reg_wr   = 1'b1;
    d.flag_wr  = 1'b1;
    case (cmd)
      CMD_ADD: d.alu_ctrl = ALU_ADD;
      CMD_SUB: d.alu_ctrl = ALU_SUB;
      CMD_CMP: begin
        d.alu_ctrl = ALU_SUB;
        d.reg_wr   = 1'b0;
      end
      CMD_AND: d.alu_ctrl = ALU_AND;
      CMD_ORR: d.alu_ctrl = ALU_ORR;
      CMD_EOR: d.alu_ctrl = ALU_EOR;
      default: begin
        d.alu_ctrl = ALU_ADD;
        d.reg_wr   = 1'b0;
        d.flag_wr  = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_mc_controller_condlogic.sv
// -----------------------------------------------------------------------------
// condlogic
// Holds the NZCV flag register and evaluates the instruction condition code
// against the registered flags.
// Ports:
//   clk       in  core clock, rising edge
//   reset     in  asynchronous, active-high; clears the flags
//   cond      in  [3:0] condition field of the current instruction
//   alu_flags in  [3:0] NZCV produced by the ALU this cycle
//   flag_we   in  load alu_flags into the flag register at the next edge
//   condex    out condition passes for the registered flags
// -----------------------------------------------------------------------------
module condlogic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_we,
  output logic       condex
);

  logic [3:0] flags;
  logic       n, z, c, v;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        flags <= 4'b0000;
    else if (flag_we) flags <= alu_flags;
  end

  assign {n, z, c, v} = flags;

  always_comb begin
    case (cond)
      4'b0000: condex = z;                 // EQ
      4'b0001: condex = ~z;                // NE
      4'b0010: condex = c;                 // CS
      4'b0011: condex = ~c;                // CC
      4'b0100: condex = n;                 // MI
      4'b0101: condex = ~n;                // PL
      4'b0110: condex = v;                 // VS
      4'b0111: condex = ~v;                // VC
      4'b1000: condex = c & ~z;            // HI
      4'b1001: condex = ~c | z;            // LS
      4'b1010: condex = ~(n ^ v);          // GE
      4'b1011: condex = n ^ v;             // LT
      4'b1100: condex = ~z & ~(n ^ v);     // GT
      4'b1101: condex = z | (n ^ v);       // LE
      COND_AL: condex = 1'b1;              // AL
      default: condex = 1'b0;              // 1111 never executes
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// -----------------------------------------------------------------------------
// arm_mc_controller
// Moore-style multicycle control unit. One memory port is shared between
// instruction fetch and data access; accesses use a MemReq/MemReady handshake
// with a wait-state timeout that halts the core and raises a sticky Fault.
// Parameters:
//   WAIT_EN   1: honour MemReady; 0: every access completes in its issue cycle
//   MAX_WAIT  unanswered MemReq cycles tolerated before Fault (1..255)
// Ports:
//   clk, reset             clock / asynchronous active-high reset
//   Instr[19:0]            Instr[31:12] from the IR: cond, op, I, cmd, S, Rn, Rd
//   ALUFlags[3:0]          NZCV from the ALU this cycle
//   MemReady               memory completes the current access this cycle
//   MemReq, MemWrite       memory request / store strobe
//   AdrSrc                 0 PC address, 1 ALUOut address
//   IRWrite, PCWrite       IR / PC load enables
//   RegWrite, RegSrc[1:0]  register file write enable / read-port selects
//   ImmSrc[1:0]            extender mode
//   ALUSrcA, ALUSrcB[1:0]  ALU operand selects
//   ResultSrc[1:0]         result bus select
//   ALUControl[2:0]        ALU operation
//   Fault                  sticky memory timeout flag
// -----------------------------------------------------------------------------
module arm_mc_controller
  import arm_pkg::*;
#(
  parameter logic WAIT_EN  = 1'b1,
  parameter int   MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic        Fault
);

  // A stall on the cycle whose increment would bring the counter to MAX_WAIT
  // is the MAX_WAIT-th unanswered cycle; that is where the timeout fires.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  // Instruction fields (port bit = architectural bit - 12)
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign i_bit     = Instr[13];
  assign cmd       = Instr[12:9];
  assign s_bit     = Instr[8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_t     state, state_n;
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       condex;
  logic       flag_we;
  logic       mem_access;
  logic       mem_done;
  logic       mem_stall;
  cmd_dec_t   dec;

  assign dec        = decode_cmd(cmd);
  assign mem_access = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign mem_done   = mem_access && (MemReady || !WAIT_EN);
  assign mem_stall  = mem_access && !mem_done;
  assign Fault      = fault_q;

  condlogic u_condlogic (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .flag_we   (flag_we),
    .condex    (condex)
  );

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_n = state;
    case (state)
      S_FETCH:  if (mem_done) state_n = S_DECODE;
      S_DECODE: begin
        if (!condex) state_n = S_FETCH;
        else begin
          case (op)
            OP_MEM: state_n = S_MEMADR;
            OP_DP:  state_n = i_bit ? S_EXECI : S_EXECR;
            OP_BR:  state_n = S_BRANCH;
            OP_NOP: state_n = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_n = s_bit ? S_MEMRD : S_MEMWR;   // S/L bit is L here
      S_MEMRD:  if (mem_done) state_n = S_MEMWB;
      S_MEMWB:  state_n = S_FETCH;
      S_MEMWR:  if (mem_done) state_n = S_FETCH;
      S_EXECR,
      S_EXECI:  state_n = S_ALUWB;
      S_ALUWB:  state_n = S_FETCH;
      S_BRANCH: state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
    end else if (mem_stall && (wait_cnt == LAST_WAIT)) begin
      state    <= S_HALT;
      wait_cnt <= 8'd0;
      fault_q  <= 1'b1;
    end else begin
      state    <= state_n;
      wait_cnt <= mem_stall ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  // Output decode
  always_comb begin
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegSrc     = 2'b00;
    ImmSrc     = IMM_ROT8;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    flag_we    = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_done;
        PCWrite   = mem_done;
      end
      S_DECODE: begin
        // PC+8 on the result bus feeds R15 reads
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_12;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        RegSrc   = 2'b10;
      end
      S_EXECR: begin
        ALUSrcB    = SRCB_RM;
        ALUControl = dec.alu_ctrl;
        flag_we    = s_bit && dec.flag_wr;
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_ROT8;
        ALUControl = dec.alu_ctrl;
        flag_we    = s_bit && dec.flag_wr;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = dec.reg_wr;
        PCWrite   = dec.reg_wr && (rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_24;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
      end
      default: ;   // S_HALT: everything idle
    endcase

    // Strobes drop the moment reset rises, aborting any access in flight.
    if (reset) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      flag_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
module tb_arm_mc_controller;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        MemReady = 1'b0;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
  logic        ALUSrcA, Fault;
  logic [2:0]  ALUControl;

  arm_mc_controller #(.WAIT_EN(1'b1), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .Fault(Fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memreq, memwrite, adrsrc, irwrite, pcwrite, regwrite;
    logic [1:0] regsrc, immsrc;
    logic       alusrca;
    logic [1:0] alusrcb, resultsrc;
    logic [2:0] aluctl;
    logic       fault;
  } outs_t;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  flags;
    logic        ready;
    outs_t       exp;
    outs_t       mask;
    string       tag;
  } cyc_t;

  cyc_t        drive_q[$];
  cyc_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          run = 1'b0;
  logic [19:0] idle_instr = '0;
  logic [3:0]  idle_flags = '0;
  logic        idle_ready = 1'b0;
  logic [19:0] cur_instr;
  logic [3:0]  cur_flags;
  logic [3:0]  mflags = 4'b0000;   // reference NZCV
  outs_t       act;
  outs_t       strobe_m;

  assign act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, RegSrc,
                ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Fault};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ARM condition table: conditions come in pairs, the odd code negating the even one.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  task automatic cmd_info(input logic [3:0] cmd, output logic [2:0] alu, output bit wr, output bit upd);
    wr = 1'b1; upd = 1'b1;
    case (cmd)
      4'b0100: alu = 3'd0;
      4'b0010: alu = 3'd1;
      4'b1010: begin alu = 3'd1; wr = 1'b0; end
      4'b0000: alu = 3'd2;
      4'b1100: alu = 3'd3;
      4'b0001: alu = 3'd4;
      default: begin alu = 3'd0; wr = 1'b0; upd = 1'b0; end
    endcase
  endtask

  task automatic push(input string tag, input logic rdy, input outs_t e, input outs_t m);
    cyc_t c;
    c.instr = cur_instr; c.flags = cur_flags; c.ready = rdy;
    c.exp = e; c.mask = m; c.tag = tag;
    drive_q.push_back(c);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; fw / mw are the
  // wait cycles inserted before the fetch / data access completes.
  task automatic gen_instr(input logic [19:0] ins, input logic [3:0] fl, input int fw, input int mw);
    outs_t e, m;
    logic [2:0] alu;
    bit wr, upd;
    cur_instr = ins; cur_flags = fl;
    cmd_info(ins[12:9], alu, wr, upd);
    for (int i = 0; i <= fw; i++) begin
      e = '0; m = strobe_m;
      e.memreq = 1; e.alusrca = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
      e.irwrite = (i == fw); e.pcwrite = (i == fw);
      m.adrsrc = 1; m.alusrca = 1; m.alusrcb = 2'b11; m.resultsrc = 2'b11; m.aluctl = 3'b111;
      push("fetch", i == fw, e, m);
    end
    e = '0; m = strobe_m;
    e.alusrca = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
    m.alusrca = 1; m.alusrcb = 2'b11; m.resultsrc = 2'b11;
    push("decode", 1'($urandom_range(0, 1)), e, m);
    if (!cond_true(ins[19:16], mflags)) return;
    case (ins[15:14])
      2'b01: begin
        e = '0; m = strobe_m;
        e.immsrc = 2'b01; e.alusrcb = 2'b01;
        m.alusrca = 1; m.alusrcb = 2'b11; m.immsrc = 2'b11; m.aluctl = 3'b111;
        push("memadr", 1'($urandom_range(0, 1)), e, m);
        for (int i = 0; i <= mw; i++) begin
          e = '0; m = strobe_m;
          e.memreq = 1; e.adrsrc = 1; m.adrsrc = 1;
          if (ins[8]) push("memrd", i == mw, e, m);
          else begin
            e.memwrite = 1; e.regsrc = 2'b10; m.regsrc = 2'b10;
            push("memwr", i == mw, e, m);
          end
        end
        if (ins[8]) begin
          e = '0; m = strobe_m;
          e.resultsrc = 2'b01; e.regwrite = 1; m.resultsrc = 2'b11;
          push("memwb", 1'($urandom_range(0, 1)), e, m);
        end
      end
      2'b00: begin
        e = '0; m = strobe_m;
        e.alusrcb = ins[13] ? 2'b01 : 2'b00; e.aluctl = alu;
        m.alusrcb = 2'b11; m.aluctl = 3'b111;
        if (ins[13]) m.immsrc = 2'b11;
        push(ins[13] ? "execi" : "execr", 1'($urandom_range(0, 1)), e, m);
        if (ins[8] && upd) mflags = fl;
        e = '0; m = strobe_m;
        e.regwrite = wr; e.pcwrite = wr && (ins[3:0] == 4'd15);
        m.resultsrc = 2'b11;
        push("aluwb", 1'($urandom_range(0, 1)), e, m);
      end
      2'b10: begin
        e = '0; m = strobe_m;
        e.alusrcb = 2'b01; e.immsrc = 2'b10; e.resultsrc = 2'b10; e.pcwrite = 1;
        m.alusrca = 1; m.alusrcb = 2'b11; m.immsrc = 2'b11; m.resultsrc = 2'b11; m.aluctl = 3'b111;
        push("branch", 1'($urandom_range(0, 1)), e, m);
      end
      default: ;
    endcase
  endtask

  function automatic logic [19:0] rand_instr();
    logic [3:0] cond, cmd, rd, rn;
    logic [1:0] op;
    logic [3:0] cmds[6] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001};
    cond = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1110;
    op   = 2'($urandom_range(0, 3));
    cmd  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 5)];
    rd   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
    rn   = 4'($urandom);
    return {cond, op, 1'($urandom), cmd, 1'($urandom), rn, rd};
  endfunction

  // Driver: one queued cycle per clock, idle values otherwise.
  initial forever begin
    cyc_t c;
    @(posedge clk);
    #2;
    if (run && drive_q.size() > 0) begin
      c = drive_q.pop_front();
      Instr = c.instr; ALUFlags = c.flags; MemReady = c.ready;
      exp_q.push_back(c);
    end else begin
      Instr = idle_instr; ALUFlags = idle_flags; MemReady = idle_ready;
    end
  end

  // Monitor: compare each presented cycle against the scoreboard head.
  int ncyc = 0;
  always @(negedge clk) begin
    cyc_t c;
    if (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      ncyc++;
      check($sformatf("%s@%0d", c.tag, ncyc), 32'(act & c.mask), 32'(c.exp & c.mask));
    end
  end

  initial begin
    strobe_m = '0;
    strobe_m.memreq = 1; strobe_m.memwrite = 1; strobe_m.irwrite = 1;
    strobe_m.pcwrite = 1; strobe_m.regwrite = 1; strobe_m.fault = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 32'({MemReq, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_fetch_sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
          32'({1'b0, 1'b1, 2'b10, 2'b10, 3'b000}));

    gen_instr(20'h0A000, 4'h0, 0, 0);   // BEQ with reset flags: not taken
    gen_instr(20'hE0821, 4'h3, 0, 0);   // ADD R1,R2,R3
    gen_instr(20'hE5921, 4'h0, 0, 2);   // LDR R1,[R2,#4], 2 wait cycles
    gen_instr(20'hE0500, 4'b0100, 0, 0); // SUBS R0,R0,R0 -> Z
    gen_instr(20'h0A000, 4'h0, 0, 0);   // BEQ taken
    gen_instr(20'hE0500, 4'b0000, 0, 0); // SUBS -> Z cleared
    gen_instr(20'h0A000, 4'h0, 0, 0);   // BEQ not taken
    gen_instr(20'hE3510, 4'b1000, 0, 0); // CMP R1,#5
    gen_instr(20'hE5821, 4'h0, 1, 1);   // STR with waits
    for (int k = 0; k < 200; k++)
      gen_instr(rand_instr(), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));

    @(posedge clk); #1;
    reset = 1'b0; run = 1'b1;
    for (int k = 0; k < 20000 && (drive_q.size() > 0 || exp_q.size() > 0); k++)
      @(posedge clk);
    check("drain_drive", 32'(drive_q.size()), 32'd0);
    check("drain_exp", 32'(exp_q.size()), 32'd0);
    run = 1'b0;

    // Timeout: MemReady stuck low in FETCH
    idle_ready = 1'b0; idle_instr = 20'hE0821;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= MAXW; k++) begin
      @(negedge clk);
      check($sformatf("to_req%0d", k), 32'({MemReq, Fault}), 32'(2'b10));
      @(posedge clk);
    end
    @(negedge clk);
    check("to_fault", 32'(Fault), 32'd1);
    check("halt_strobes", 32'({MemReq, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
    idle_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halt_sticky", 32'({MemReq, IRWrite, Fault}), 32'(3'b001));
    #1 reset = 1'b1;
    #1 check("rst_clr_fault", 32'(Fault), 32'd0);

    // Reset during a MEMWR wait cycle
    idle_instr = 20'hE5821; idle_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 idle_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("memwr_wait", 32'({MemReq, MemWrite, AdrSrc}), 32'(3'b111));
    #1 reset = 1'b1;
    #1 check("memwr_abort", 32'({MemReq, MemWrite}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", 32'({MemReq, MemWrite, AdrSrc, IRWrite}), 32'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
